tnn_neuron_sched: RTL and testbench
===================================

Name: tnn_neuron_sched

Overview:
- Time-multiplexes one shared 3-bit TNN neuron comparator across the neurons of a layer.
- The comparator is a combinational unit producing one output bit from operands a, b and threshold c.
- Accepts a stream of per-neuron operand triples, issues each to the comparator through registers and captures the result bit.
- Packs the bits into one layer-output word, handed downstream with a valid/ready handshake.

Parameters:
- IN_W, 3, width of each operand (a, b, c).
- N_NEURONS, 8, maximum neurons per layer word (bits in out_bits); must be >= 2.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand triple valid.
- in_ready  output  1  scheduler can accept a triple.
- in_a  input  IN_W  neuron operand a.
- in_b  input  IN_W  neuron operand b.
- in_c  input  IN_W  neuron threshold c.
- in_last  input  1  final neuron of the layer word.
- cmp_a  output  IN_W  registered operand a to the comparator.
- cmp_b  output  IN_W  registered operand b to the comparator.
- cmp_c  output  IN_W  registered threshold c to the comparator.
- cmp_out  input  1  comparator result (combinational from cmp_*).
- out_valid  output  1  layer word valid.
- out_ready  input  1  downstream accepts the word.
- out_bits  output  N_NEURONS  neuron i result in bit i; unused bits 0.
- out_count  output  clog2(N_NEURONS+1)  number of valid neurons in the word.
- busy  output  1  high in any state other than COLLECT with idx=0 and no capture pending.

Behaviour:
- Reset (async): state=COLLECT, idx=0, cap_pend=0, cmp_a/b/c=0, out_bits=0, out_count=0, out_valid=0. in_ready is 1 after reset. Reset mid-word discards all partial results.
- States:
  - COLLECT: in_ready=1.
  - FLUSH: in_ready=0, out_valid=0.
  - OUTPUT: in_ready=0, out_valid=1.
- Accept = in_valid & in_ready.
- On accept in cycle t:
  - cmp_a/b/c load in_a/b/c at the edge ending t.
  - cap_pend=1 and cap_idx=idx for cycle t+1.
  - During t+1, cmp_out is sampled into out_bits[cap_idx] at the edge ending t+1.
  - Throughput is one triple per cycle in COLLECT; capture of beat k overlaps accept of beat k+1.
- Word end: an accepted beat with in_last=1 or idx==N_NEURONS-1.
  - Go to FLUSH, with out_count=idx+1 and idx reset to 0.
  - FLUSH lasts exactly one cycle (the final capture), then OUTPUT.
  - out_valid rises 2 cycles after the final accept.
- cmp_a/b/c hold their last value when no accept occurs; cmp_out is ignored when cap_pend=0.
- OUTPUT: out_bits and out_count are stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready: out_valid=0, out_bits cleared to 0, state=COLLECT.
  - in_ready rises in the cycle after the handshake (no same-cycle bypass).
- Single-neuron word (in_last on first beat): out_count=1, only bit 0 meaningful.
- in_last is ignored on non-accepted cycles. in_valid without in_ready holds no state.
- Operand changes while in_valid=1 and in_ready=0 have no effect.

Optional Feature:
- Macro: TNN_SCHED_EXACT_CHECK_EN.
- Defined:
  - Each capture also computes exact = ({1'b0,cmp_a}+{1'b0,cmp_b}) >= {1'b0,cmp_c}, as an (IN_W+1)-bit sum compare.
  - When cmp_out != exact, a 16-bit saturating counter mismatch_cnt increments.
  - mismatch_cnt is an extra output port, reset to 0 by rst only; it does not clear per word.
  - Also adds output mismatch_word: sticky per word, cleared on the output handshake.
- Not defined: no extra ports or logic; all other behaviour is identical.

Test Plan:
- In all scenarios the bench models cmp_out = (cmp_a+cmp_b >= cmp_c), exact.
- Full word: 8 back-to-back triples (a,b,c) = (3,2,4),(0,0,1),(7,7,7),(1,1,3),(4,3,7),(2,2,5),(0,1,1),(6,0,7), last on beat 8, out_ready=1.
  - Required: out_bits=8'b0101_0101, out_count=8.
  - out_valid exactly 2 cycles after the 8th accept.
  - in_ready continuously 1 during beats 1-8.
- Short word: 3 triples (5,5,2),(0,0,0),(1,0,2) with in_last on 3rd.
  - Required: out_bits=8'b0000_0011, out_count=3.
- Backpressure: out_ready=0 for 5 cycles after out_valid.
  - out_bits/out_count stable, in_ready=0 throughout.
  - After the handshake, in_ready=1 one cycle later and the next word starts at bit 0.
- Bubbles: in_valid toggled 1,0,0,1,0,1 with 3 triples.
  - Results identical to the back-to-back case; cmp_* hold between accepts.
- Reset mid-word: assert rst after 4 accepts.
  - Immediately out_valid=0, cmp_*=0, in_ready=1 after release.
  - A following 2-beat word reports out_count=2 with no stale bits.
- With TNN_SCHED_EXACT_CHECK_EN, bench forces cmp_out inverted on 2 of 8 beats.
  - Required: mismatch_cnt=2 and mismatch_word=1, cleared on the output handshake.

Source files
------------

// File: rtl/tnn_neuron_sched.sv
// Scheduler that time-multiplexes one shared TNN comparator across a layer's neurons and
// packs the result bits into a layer word. Optional macro: TNN_SCHED_EXACT_CHECK_EN.
module tnn_neuron_sched #(
    parameter int unsigned IN_W      = 3,
    parameter int unsigned N_NEURONS = 8,
    localparam int unsigned CntW     = $clog2(N_NEURONS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_W-1:0]      in_a,
    input  logic [IN_W-1:0]      in_b,
    input  logic [IN_W-1:0]      in_c,
    input  logic                 in_last,
    output logic [IN_W-1:0]      cmp_a,
    output logic [IN_W-1:0]      cmp_b,
    output logic [IN_W-1:0]      cmp_c,
    input  logic                 cmp_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N_NEURONS-1:0] out_bits,
    output logic [CntW-1:0]      out_count,
    output logic                 busy
`ifdef TNN_SCHED_EXACT_CHECK_EN
    ,
    output logic [15:0]          mismatch_cnt,
    output logic                 mismatch_word
`endif
);

    localparam int unsigned IdxW = $clog2(N_NEURONS);

    typedef enum logic [1:0] {
        StCollect,
        StFlush,
        StOutput
    } state_e;

    state_e                state_q, state_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [IdxW-1:0]       cap_idx_q, cap_idx_d;
    logic                  cap_pend_q, cap_pend_d;
    logic [IN_W-1:0]       cmp_a_q, cmp_a_d;
    logic [IN_W-1:0]       cmp_b_q, cmp_b_d;
    logic [IN_W-1:0]       cmp_c_q, cmp_c_d;
    logic [N_NEURONS-1:0]  out_bits_q, out_bits_d;
    logic [CntW-1:0]       out_count_q, out_count_d;

    logic accept;
    logic word_end;
    logic handshake;

    assign in_ready  = (state_q == StCollect);
    assign out_valid = (state_q == StOutput);
    assign accept    = in_valid & in_ready;
    assign word_end  = accept & (in_last | (idx_q == IdxW'(N_NEURONS - 1)));
    assign handshake = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cap_idx_d   = cap_idx_q;
        cap_pend_d  = accept;
        cmp_a_d     = cmp_a_q;
        cmp_b_d     = cmp_b_q;
        cmp_c_d     = cmp_c_q;
        out_bits_d  = out_bits_q;
        out_count_d = out_count_q;

        // Capture of the previous beat overlaps acceptance of the next one.
        if (cap_pend_q) begin
            out_bits_d[cap_idx_q] = cmp_out;
        end

        case (state_q)
            StCollect: begin
                if (accept) begin
                    cmp_a_d   = in_a;
                    cmp_b_d   = in_b;
                    cmp_c_d   = in_c;
                    cap_idx_d = idx_q;
                    idx_d     = idx_q + IdxW'(1);
                    if (word_end) begin
                        idx_d       = '0;
                        out_count_d = CntW'(idx_q) + CntW'(1);
                        state_d     = StFlush;
                    end
                end
            end
            StFlush: begin
                state_d = StOutput;
            end
            StOutput: begin
                if (handshake) begin
                    out_bits_d = '0;
                    state_d    = StCollect;
                end
            end
            default: begin
                state_d = StCollect;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StCollect;
            idx_q       <= '0;
            cap_idx_q   <= '0;
            cap_pend_q  <= 1'b0;
            cmp_a_q     <= '0;
            cmp_b_q     <= '0;
            cmp_c_q     <= '0;
            out_bits_q  <= '0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cap_idx_q   <= cap_idx_d;
            cap_pend_q  <= cap_pend_d;
            cmp_a_q     <= cmp_a_d;
            cmp_b_q     <= cmp_b_d;
            cmp_c_q     <= cmp_c_d;
            out_bits_q  <= out_bits_d;
            out_count_q <= out_count_d;
        end
    end

    assign cmp_a     = cmp_a_q;
    assign cmp_b     = cmp_b_q;
    assign cmp_c     = cmp_c_q;
    assign out_bits  = out_bits_q;
    assign out_count = out_count_q;
    assign busy      = !((state_q == StCollect) && (idx_q == '0) && !cap_pend_q);

`ifdef TNN_SCHED_EXACT_CHECK_EN
    logic        exact;
    logic        mismatch;
    logic [15:0] mismatch_cnt_q, mismatch_cnt_d;
    logic        mismatch_word_q, mismatch_word_d;

    // Reference compare uses a widened sum so a+b cannot wrap.
    assign exact    = ({1'b0, cmp_a_q} + {1'b0, cmp_b_q}) >= {1'b0, cmp_c_q};
    assign mismatch = cap_pend_q & (cmp_out != exact);

    always_comb begin
        mismatch_cnt_d  = mismatch_cnt_q;
        mismatch_word_d = mismatch_word_q;
        if (mismatch && (mismatch_cnt_q != 16'hFFFF)) begin
            mismatch_cnt_d = mismatch_cnt_q + 16'd1;
        end
        if (handshake) begin
            mismatch_word_d = 1'b0;
        end else if (mismatch) begin
            mismatch_word_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch_cnt_q  <= '0;
            mismatch_word_q <= 1'b0;
        end else begin
            mismatch_cnt_q  <= mismatch_cnt_d;
            mismatch_word_q <= mismatch_word_d;
        end
    end

    assign mismatch_cnt  = mismatch_cnt_q;
    assign mismatch_word = mismatch_word_q;
`endif

endmodule

// File: tb/tb_tnn_neuron_sched.sv
// Scoreboard bench for tnn_neuron_sched: stimulus pushes expected layer words, a monitor
// pops them on each output handshake. The shared comparator is modelled as a+b >= c.
module tb_tnn_neuron_sched;

    localparam int unsigned IN_W = 3;
    localparam int unsigned N    = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [IN_W-1:0] in_a = '0, in_b = '0, in_c = '0;
    logic            in_last = 1'b0;
    logic [IN_W-1:0] cmp_a, cmp_b, cmp_c;
    logic            cmp_out;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [N-1:0]    out_bits;
    logic [3:0]      out_count;
    logic            busy;
    logic            force_inv = 1'b0;
`ifdef TNN_SCHED_EXACT_CHECK_EN
    logic [15:0]     mismatch_cnt;
    logic            mismatch_word;
`endif

    tnn_neuron_sched #(
        .IN_W      (IN_W),
        .N_NEURONS (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .in_last   (in_last),
        .cmp_a     (cmp_a),
        .cmp_b     (cmp_b),
        .cmp_c     (cmp_c),
        .cmp_out   (cmp_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bits  (out_bits),
        .out_count (out_count),
        .busy      (busy)
`ifdef TNN_SCHED_EXACT_CHECK_EN
        ,
        .mismatch_cnt  (mismatch_cnt),
        .mismatch_word (mismatch_word)
`endif
    );

    always #5 clk = ~clk;

    // Environment comparator, optionally corrupted to exercise the mismatch counter.
    assign cmp_out = ((int'(cmp_a) + int'(cmp_b)) >= int'(cmp_c)) ^ force_inv;

    typedef struct {
        logic [N-1:0] bits;
        int           count;
    } exp_t;

    exp_t         sb[$];
    int           checks   = 0;
    int           failures = 0;
    int           stalls   = 0;
    logic [N-1:0] last_exp_bits;
    logic [2:0]   va[N], vb[N], vc[N];
    bit           rand_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int n, input logic [N-1:0] inv_mask);
        exp_t e;
        e.bits  = '0;
        e.count = n;
        for (int i = 0; i < n; i++) begin
            e.bits[i] = ((int'(va[i]) + int'(vb[i])) >= int'(vc[i])) ^ inv_mask[i];
        end
        last_exp_bits = e.bits;
        sb.push_back(e);
    endtask

    task automatic idle(input int k);
        in_valid = 1'b0;
        repeat (k) begin
            in_a    = 3'($urandom);
            in_b    = 3'($urandom);
            in_c    = 3'($urandom);
            in_last = 1'b1;
            @(posedge clk);
            #1;
            force_inv = 1'b0;
        end
        in_last = 1'b0;
    endtask

    task automatic send(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                        input bit last, input bit inv);
        in_a     = a;
        in_b     = b;
        in_c     = c;
        in_last  = last;
        in_valid = 1'b1;
        while (!in_ready) begin
            stalls++;
            @(posedge clk);
            #1;
            force_inv = 1'b0;
        end
        @(posedge clk);
        #1;
        force_inv = inv;
        in_valid  = 1'b0;
        in_last   = 1'b0;
    endtask

    task automatic send_word(input int n, input bit use_last, input logic [N-1:0] inv_mask,
                             input int bubble_max);
        push_exp(n, inv_mask);
        for (int i = 0; i < n; i++) begin
            if (i > 0 && bubble_max > 0) idle($urandom_range(0, bubble_max));
            send(va[i], vb[i], vc[i], use_last && (i == n - 1), inv_mask[i]);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++) begin
            va[i] = 3'($urandom_range(0, 7));
            vb[i] = 3'($urandom_range(0, 7));
            vc[i] = 3'($urandom_range(0, 7));
        end
    endtask

    task automatic wait_ready();
        while (!in_ready) begin
            @(posedge clk);
            #1;
            force_inv = 1'b0;
        end
    endtask

    task automatic wait_valid();
        while (!out_valid) begin
            @(posedge clk);
            #1;
            force_inv = 1'b0;
        end
    endtask

    // Monitor: every output handshake must match the oldest expected word.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_word", 32'(out_bits), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_bits", 32'(out_bits), 32'(e.bits));
                    chk("sb_count", 32'(out_count), 32'(e.count));
                end
            end
        end
    end

    initial begin
        #400000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int s0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_cmp_a", 32'(cmp_a), 0);
        chk("rst_cmp_c", 32'(cmp_c), 0);
        chk("rst_out_bits", 32'(out_bits), 0);
        chk("rst_out_count", 32'(out_count), 0);
        chk("rst_busy", 32'(busy), 0);
`ifdef TNN_SCHED_EXACT_CHECK_EN
        chk("rst_mismatch_cnt", 32'(mismatch_cnt), 0);
`endif

        // Full word, back-to-back.
        va = '{3'd3, 3'd0, 3'd7, 3'd1, 3'd4, 3'd2, 3'd0, 3'd6};
        vb = '{3'd2, 3'd0, 3'd7, 3'd1, 3'd3, 3'd2, 3'd1, 3'd0};
        vc = '{3'd4, 3'd1, 3'd7, 3'd3, 3'd7, 3'd5, 3'd1, 3'd7};
        s0 = stalls;
        send_word(8, 1'b1, '0, 0);
        chk("full_no_stall", 32'(stalls - s0), 0);
        chk("full_flush_valid", 32'(out_valid), 0);
        @(posedge clk);
        #1;
        chk("full_valid_t2", 32'(out_valid), 1);
        chk("full_bits", 32'(out_bits), 32'h55);
        chk("full_count", 32'(out_count), 8);
        wait_ready();

        // Short word.
        va = '{3'd5, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        vb = '{3'd5, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        vc = '{3'd2, 3'd0, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        send_word(3, 1'b1, '0, 0);
        @(posedge clk);
        #1;
        chk("short_bits", 32'(out_bits), 32'h03);
        chk("short_count", 32'(out_count), 3);
        wait_ready();

        // Same triples with bubbles 1,0,0,1,0,1.
        push_exp(3, '0);
        send(va[0], vb[0], vc[0], 1'b0, 1'b0);
        idle(2);
        chk("bubble_hold_a", 32'(cmp_a), 32'(va[0]));
        chk("bubble_hold_b", 32'(cmp_b), 32'(vb[0]));
        chk("bubble_hold_c", 32'(cmp_c), 32'(vc[0]));
        chk("bubble_busy", 32'(busy), 1);
        send(va[1], vb[1], vc[1], 1'b0, 1'b0);
        idle(1);
        chk("bubble_hold_a1", 32'(cmp_a), 32'(va[1]));
        send(va[2], vb[2], vc[2], 1'b1, 1'b0);
        wait_ready();

        // Backpressure.
        out_ready = 1'b0;
        fill_random();
        send_word(5, 1'b1, '0, 0);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_bits", 32'(out_bits), 32'(last_exp_bits));
            chk("bp_count", 32'(out_count), 5);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        chk("bp_hs_in_ready", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        chk("bp_post_in_ready", 32'(in_ready), 1);
        chk("bp_post_bits", 32'(out_bits), 0);
        fill_random();
        send_word(2, 1'b1, '0, 0);
        wait_ready();

        // Reset mid-word.
        fill_random();
        for (int i = 0; i < 4; i++) send(va[i], vb[i], vc[i], 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        force_inv = 1'b0;
        chk("mrst_out_valid", 32'(out_valid), 0);
        chk("mrst_cmp_a", 32'(cmp_a), 0);
        chk("mrst_cmp_b", 32'(cmp_b), 0);
        chk("mrst_cmp_c", 32'(cmp_c), 0);
        chk("mrst_bits", 32'(out_bits), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mrst_in_ready", 32'(in_ready), 1);
        chk("mrst_busy", 32'(busy), 0);
        fill_random();
        send_word(2, 1'b1, '0, 0);
        @(posedge clk);
        #1;
        chk("mrst_count", 32'(out_count), 2);
        chk("mrst_bits_after", 32'(out_bits), 32'(last_exp_bits));
        wait_ready();

        // Randomized words with random bubbles and random downstream backpressure.
        rand_on = 1'b1;
        fork
            begin
                while (rand_on) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join_none
        for (int w = 0; w < 24; w++) begin
            int  n;
            bit  ul;
            fill_random();
            n  = $urandom_range(1, 8);
            ul = (n < 8) ? 1'b1 : 1'($urandom_range(0, 1));
            send_word(n, ul, '0, 2);
        end
        rand_on = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_ready();

`ifdef TNN_SCHED_EXACT_CHECK_EN
        // Two corrupted comparator results in one word.
        out_ready = 1'b0;
        va = '{3'd3, 3'd0, 3'd7, 3'd1, 3'd4, 3'd2, 3'd0, 3'd6};
        vb = '{3'd2, 3'd0, 3'd7, 3'd1, 3'd3, 3'd2, 3'd1, 3'd0};
        vc = '{3'd4, 3'd1, 3'd7, 3'd3, 3'd7, 3'd5, 3'd1, 3'd7};
        send_word(8, 1'b1, 8'b0010_0100, 0);
        wait_valid();
        chk("mm_cnt", 32'(mismatch_cnt), 2);
        chk("mm_word", 32'(mismatch_word), 1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("mm_word_clr", 32'(mismatch_word), 0);
        chk("mm_cnt_kept", 32'(mismatch_cnt), 2);
        wait_ready();
`endif

        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
